mantissa_mul_iter: RTL and testbench

MANTISSA_MUL_ITER -- requirements
Module: mantissa_mul_iter

---
 rtl/mantissa_mul_iter_if.sv | 26 ++
 rtl/mantissa_mul_iter.sv | 135 +++++++++++++
 tb/tb_mantissa_mul_iter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mantissa_mul_iter_if.sv
// rtl/mantissa_mul_iter_if.sv - operand/result handshake bundle for the iterative mantissa multiplier
interface mantissa_mul_iter_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  E_A;
  logic [7:0]  E_B;
  logic [23:0] M_A;
  logic [23:0] M_B;
  logic        sign_in;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] product;
  logic [9:0]  exp_sum;
  logic        sign_out;
  logic        busy;

  modport slave (
    input  in_valid, E_A, E_B, M_A, M_B, sign_in, out_ready,
    output in_ready, out_valid, product, exp_sum, sign_out, busy
  );

  modport master (
    output in_valid, E_A, E_B, M_A, M_B, sign_in, out_ready,
    input  in_ready, out_valid, product, exp_sum, sign_out, busy
  );
endinterface

// File: rtl/mantissa_mul_iter.sv
// rtl/mantissa_mul_iter.sv - iterative 24x24 shift-add mantissa multiplier with biased exponent sum
// Define MANTISSA_MUL_RADIX4_EN to retire two multiplier bits per cycle (12 iterations instead of 24).
module mantissa_mul_iter (
  input  logic                   clk,
  input  logic                   rst_n,
  mantissa_mul_iter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef MANTISSA_MUL_RADIX4_EN
  localparam logic [4:0] LAST_ITER = 5'd11;
`else
  localparam logic [4:0] LAST_ITER = 5'd23;
`endif

  state_t      state_q, state_d;
  logic [47:0] mcand_q, mcand_d;
  logic [23:0] mplier_q, mplier_d;
  logic [47:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [9:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
`ifdef MANTISSA_MUL_RADIX4_EN
  logic [47:0] tri_q, tri_d;
  logic [47:0] addend;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= 48'd0;
      mplier_q <= 24'd0;
      acc_q    <= 48'd0;
      cnt_q    <= 5'd0;
      exp_q    <= 10'd0;
      sign_q   <= 1'b0;
`ifdef MANTISSA_MUL_RADIX4_EN
      tri_q    <= 48'd0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
`ifdef MANTISSA_MUL_RADIX4_EN
      tri_q    <= tri_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
`ifdef MANTISSA_MUL_RADIX4_EN
    tri_d    = tri_q;
    addend   = 48'd0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_d  = {24'd0, bus.M_A};
          mplier_d = bus.M_B;
          acc_d    = 48'd0;
          cnt_d    = 5'd0;
          exp_d    = {2'b00, bus.E_A} + {2'b00, bus.E_B} - 10'd127;
          sign_d   = bus.sign_in;
`ifdef MANTISSA_MUL_RADIX4_EN
          tri_d    = {24'd0, bus.M_A} + {23'd0, bus.M_A, 1'b0};
`endif
          state_d  = RUN;
        end
      end

      RUN: begin
`ifdef MANTISSA_MUL_RADIX4_EN
        // 3A is kept shifted alongside A so each digit is a single add
        case (mplier_q[1:0])
          2'b00:   addend = 48'd0;
          2'b01:   addend = mcand_q;
          2'b10:   addend = {mcand_q[46:0], 1'b0};
          default: addend = tri_q;
        endcase
        acc_d    = acc_q + addend;
        mcand_d  = {mcand_q[45:0], 2'b00};
        tri_d    = {tri_q[45:0], 2'b00};
        mplier_d = {2'b00, mplier_q[23:2]};
`else
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = {mcand_q[46:0], 1'b0};
        mplier_d = {1'b0, mplier_q[23:1]};
`endif
        cnt_d = cnt_q + 5'd1;
        // Fixed iteration count; zero operands still take the full latency
        if (cnt_q == LAST_ITER) begin
          cnt_d   = cnt_q;
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.product   = acc_q;
  assign bus.exp_sum   = exp_q;
  assign bus.sign_out  = sign_q;

endmodule

// File: tb/tb_mantissa_mul_iter.sv
// tb/tb_mantissa_mul_iter.sv - directed self-checking bench for mantissa_mul_iter
module tb_mantissa_mul_iter;

`ifdef MANTISSA_MUL_RADIX4_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 24;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cycles;

  mantissa_mul_iter_if bus ();

  mantissa_mul_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] ea, input logic [7:0] eb,
                        input logic [23:0] ma, input logic [23:0] mb, input logic s);
    bus.E_A      = ea;
    bus.E_B      = eb;
    bus.M_A      = ma;
    bus.M_B      = mb;
    bus.sign_in  = s;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    cycles = 0;
    while (!bus.out_valid && cycles < 100) begin
      tick();
      cycles++;
    end
    checks++;
    if (cycles !== LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, cycles, LAT);
    end
  endtask

  task automatic pop(input string name);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s pop: in_ready=%b out_valid=%b, expected 1/0", name, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: in_ready=%b out_valid=%b busy=%b, expected 1/0/0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    checks++;
    if (bus.product !== 48'd0 || bus.exp_sum !== 10'd0 || bus.sign_out !== 1'b0) begin
      errors++;
      $display("FAIL reset data: product=%h exp_sum=%h sign=%b, expected 0/0/0",
               bus.product, bus.exp_sum, bus.sign_out);
    end
  endtask

  task automatic test_unit();
    accept(8'd127, 8'd127, 24'h800000, 24'h800000, 1'b0);
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL unit run flags: busy=%b in_ready=%b, expected 1/0", bus.busy, bus.in_ready);
    end
    wait_valid("unit");
    checks++;
    if (bus.product !== 48'h400000000000 || bus.exp_sum !== 10'd127 || bus.sign_out !== 1'b0) begin
      errors++;
      $display("FAIL unit result: product=%h exp=%0d sign=%b, expected 400000000000/127/0",
               bus.product, bus.exp_sum, bus.sign_out);
    end
    pop("unit");
  endtask

  task automatic test_max();
    accept(8'd254, 8'd254, 24'hFFFFFF, 24'hFFFFFF, 1'b0);
    wait_valid("max");
    checks++;
    if (bus.product !== 48'hFFFFFE000001 || bus.exp_sum !== 10'd381) begin
      errors++;
      $display("FAIL max result: product=%h exp=%0d, expected fffffe000001/381", bus.product, bus.exp_sum);
    end
    pop("max");
  endtask

  task automatic test_zero();
    accept(8'd0, 8'd0, 24'h000000, 24'hC00000, 1'b1);
    wait_valid("zero");
    checks++;
    if (bus.product !== 48'd0 || bus.exp_sum !== 10'h381 || bus.sign_out !== 1'b1) begin
      errors++;
      $display("FAIL zero result: product=%h exp=%h sign=%b, expected 0/381/1",
               bus.product, bus.exp_sum, bus.sign_out);
    end
    pop("zero");
  endtask

  task automatic test_backpressure();
    logic [47:0] p;
    logic [9:0]  e;
    accept(8'd200, 8'd10, 24'hC00000, 24'hC00000, 1'b0);
    // changing inputs during RUN must not disturb the operation
    bus.in_valid = 1'b1;
    bus.M_A      = 24'h123456;
    bus.E_A      = 8'd5;
    wait_valid("bp");
    p = bus.product;
    e = bus.exp_sum;
    checks++;
    if (p !== 48'h900000000000 || e !== 10'd83) begin
      errors++;
      $display("FAIL bp result: product=%h exp=%0d, expected 900000000000/83", p, e);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.product !== 48'h900000000000 || bus.exp_sum !== 10'd83 ||
          bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp hold %0d: product=%h exp=%0d out_valid=%b in_ready=%b",
                 i, bus.product, bus.exp_sum, bus.out_valid, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    pop("bp");
  endtask

  task automatic test_reset_abort();
    accept(8'd100, 8'd100, 24'h123456, 24'h654321, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.product !== 48'd0 || bus.in_ready !== 1'b1 ||
        bus.busy !== 1'b0 || bus.sign_out !== 1'b0) begin
      errors++;
      $display("FAIL abort state: out_valid=%b product=%h in_ready=%b busy=%b sign=%b",
               bus.out_valid, bus.product, bus.in_ready, bus.busy, bus.sign_out);
    end
    accept(8'd130, 8'd1, 24'h800001, 24'h000003, 1'b0);
    wait_valid("post_abort");
    checks++;
    if (bus.product !== 48'h000001800003 || bus.exp_sum !== 10'd4) begin
      errors++;
      $display("FAIL post_abort result: product=%h exp=%0d, expected 000001800003/4",
               bus.product, bus.exp_sum);
    end
    pop("post_abort");
  endtask

  task automatic test_back_to_back();
    accept(8'd1, 8'd2, 24'h800001, 24'h800001, 1'b1);
    wait_valid("b2b_a");
    checks++;
    if (bus.product !== 48'h400001000001 || bus.exp_sum !== 10'h381 + 10'd3 || bus.sign_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_a result: product=%h exp=%h sign=%b, expected 400001000001/384/1",
               bus.product, bus.exp_sum, bus.sign_out);
    end
    pop("b2b_a");
    accept(8'd255, 8'd255, 24'hFFFFFF, 24'h000001, 1'b0);
    wait_valid("b2b_b");
    checks++;
    if (bus.product !== 48'h000000FFFFFF || bus.exp_sum !== 10'd383 || bus.sign_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_b result: product=%h exp=%0d sign=%b, expected 000000ffffff/383/0",
               bus.product, bus.exp_sum, bus.sign_out);
    end
    pop("b2b_b");
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.E_A       = 8'd0;
    bus.E_B       = 8'd0;
    bus.M_A       = 24'd0;
    bus.M_B       = 24'd0;
    bus.sign_in   = 1'b0;
    #1;
    test_reset();
    test_unit();
    test_max();
    test_zero();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
